// File: rtl/rop3_pkg.sv
// Shared ROP3 definitions: recovery FSM states, the mode-code width and
// the minterm index used by both the ROP3 engines and the mode observer.
package rop3_pkg;

    localparam int MODE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ERROR   = 2'd3
    } rop3_state_e;

    // The pattern bit is the most significant bit of the index, the destination bit the least.
    function automatic logic [2:0] minterm_idx(input logic p, input logic s, input logic d);
        return {p, s, d};
    endfunction

endpackage

// File: rtl/rop3_minterm_merge.sv
// Folds the N bit-position observations of one word into per-minterm evidence
// and checks it for self-consistency and against what is already known.
module rop3_minterm_merge
    import rop3_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]      P,
    input  logic [N-1:0]      S,
    input  logic [N-1:0]      D,
    input  logic [N-1:0]      Result,
    input  logic [MODE_W-1:0] known_mask,
    input  logic [MODE_W-1:0] Mode_out,
    output logic [MODE_W-1:0] hit,
    output logic [MODE_W-1:0] val,
    output logic              bad
);

    logic [MODE_W-1:0] val0;
    logic [MODE_W-1:0] val1;

    always_comb begin
        hit  = '0;
        val0 = '0;
        val1 = '0;
        for (int j = 0; j < N; j++) begin
            hit[minterm_idx(P[j], S[j], D[j])] = 1'b1;
            if (Result[j]) begin
                val1[minterm_idx(P[j], S[j], D[j])] = 1'b1;
            end else begin
                val0[minterm_idx(P[j], S[j], D[j])] = 1'b1;
            end
        end
    end

    assign val = val1;

    // Bad if one minterm is seen as both 0 and 1 in this word, or disagrees with a stored bit.
    assign bad = (|(val1 & val0)) | (|(hit & known_mask & (Mode_out ^ val1)));

endmodule

// File: rtl/rop3_mode_recover.sv
// Recovers the 8-bit ROP3 mode code from observed (P, S, D, Result) words:
// one stage of input registers, then merge into the truth-table accumulator.
module rop3_mode_recover
    import rop3_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [N-1:0]      P,
    input  logic [N-1:0]      S,
    input  logic [N-1:0]      D,
    input  logic [N-1:0]      Result,
    output logic [7:0]        Mode_out,
    output logic [7:0]        known_mask,
    output logic              out_valid,
    output logic              locked,
    output logic              conflict,
    output logic [CNT_W-1:0]  obs_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    rop3_state_e       state_q;
    logic              stg_valid_q;
    logic [N-1:0]      p_q;
    logic [N-1:0]      s_q;
    logic [N-1:0]      d_q;
    logic [N-1:0]      result_q;
    logic [MODE_W-1:0] mode_q;
    logic [MODE_W-1:0] known_q;
    logic              out_valid_q;
    logic              locked_q;
    logic              conflict_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [MODE_W-1:0] hit;
    logic [MODE_W-1:0] val;
    logic              bad;
    logic [MODE_W-1:0] known_d;
    logic [MODE_W-1:0] mode_d;

    rop3_minterm_merge #(.N(N)) u_merge (
        .P          (p_q),
        .S          (s_q),
        .D          (d_q),
        .Result     (result_q),
        .known_mask (known_q),
        .Mode_out   (mode_q),
        .hit        (hit),
        .val        (val),
        .bad        (bad)
    );

    assign known_d = known_q | hit;
    assign mode_d  = (mode_q & ~hit) | (val & hit);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q     <= ST_IDLE;
            stg_valid_q <= 1'b0;
            p_q         <= '0;
            s_q         <= '0;
            d_q         <= '0;
            result_q    <= '0;
            mode_q      <= '0;
            known_q     <= '0;
            out_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            conflict_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            stg_valid_q <= in_valid;
            p_q         <= P;
            s_q         <= S;
            d_q         <= D;
            result_q    <= Result;
            out_valid_q <= 1'b0;
            if (stg_valid_q) begin
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
                case (state_q)
                    ST_IDLE, ST_COLLECT: begin
                        if (bad) begin
                            state_q    <= ST_ERROR;
                            conflict_q <= 1'b1;
                        end else begin
                            known_q <= known_d;
                            mode_q  <= mode_d;
                            if (known_d == '1) begin
                                state_q     <= ST_LOCKED;
                                locked_q    <= 1'b1;
                                out_valid_q <= 1'b1;
                            end else begin
                                state_q <= ST_COLLECT;
                            end
                        end
                    end
                    // Once locked the mode is frozen; words are only checked against it.
                    ST_LOCKED: begin
                        if (bad) begin
                            state_q    <= ST_ERROR;
                            locked_q   <= 1'b0;
                            conflict_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Mode_out   = mode_q;
    assign known_mask = known_q;
    assign out_valid  = out_valid_q;
    assign locked     = locked_q;
    assign conflict   = conflict_q;
    assign obs_cnt    = cnt_q;

endmodule

// File: tb/tb_rop3_mode_recover.sv
// Directed bench for rop3_mode_recover: hand-computed ROP3 words, one line per transaction.
module tb_rop3_mode_recover;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [7:0]  P;
    logic [7:0]  S;
    logic [7:0]  D;
    logic [7:0]  Result;
    logic [7:0]  Mode_out;
    logic [7:0]  known_mask;
    logic        out_valid;
    logic        locked;
    logic        conflict;
    logic [15:0] obs_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    rop3_mode_recover #(.N(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .P          (P),
        .S          (S),
        .D          (D),
        .Result     (Result),
        .Mode_out   (Mode_out),
        .known_mask (known_mask),
        .out_valid  (out_valid),
        .locked     (locked),
        .conflict   (conflict),
        .obs_cnt    (obs_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] p, input logic [7:0] s, input logic [7:0] d, input logic [7:0] r);
        P = p; S = s; D = d; Result = r;
        in_valid = 1'b1;
        $display("word P=%h S=%h D=%h R=%h", p, s, d, r);
        tick();
        in_valid = 1'b0;
    endtask

    // Drive one word and wait until its effect is visible on the outputs.
    task automatic send(input logic [7:0] p, input logic [7:0] s, input logic [7:0] d, input logic [7:0] r);
        drive(p, s, d, r);
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [7:0] mode, input logic [7:0] mask,
                             input logic ov, input logic lk, input logic cf, input logic [15:0] cnt);
        check_val({tag, ".mode"},      32'(Mode_out),   32'(mode));
        check_val({tag, ".mask"},      32'(known_mask), 32'(mask));
        check_val({tag, ".out_valid"}, 32'(out_valid),  32'(ov));
        check_val({tag, ".locked"},    32'(locked),     32'(lk));
        check_val({tag, ".conflict"},  32'(conflict),   32'(cf));
        check_val({tag, ".obs_cnt"},   32'(obs_cnt),    32'(cnt));
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        P = '0; S = '0; D = '0; Result = '0;
        tick(); tick();
        rst = 1'b0;
        check_all("reset", 8'h00, 8'h00, 0, 0, 0, 16'd0);

        // Result = S: bit j is minterm j, so Result equals the mode directly.
        send(8'hF0, 8'hCC, 8'hAA, 8'hCC);
        check_all("cc_lock", 8'hCC, 8'hFF, 1, 1, 0, 16'd1);
        tick();
        check_val("cc_pulse_end", 32'(out_valid), 32'd0);
        do_clear();
        check_all("clear1", 8'h00, 8'h00, 0, 0, 0, 16'd0);

        send(8'hF0, 8'hCC, 8'hAA, 8'h5A);
        check_all("5a_lock", 8'h5A, 8'hFF, 1, 1, 0, 16'd1);
        // Upper nibble hits minterm 4 (=1), lower nibble minterm 5 (=0): consistent.
        send(8'hFF, 8'h00, 8'h0F, 8'hF0);
        check_all("5a_follow", 8'h5A, 8'hFF, 0, 1, 0, 16'd2);
        do_clear();

        send(8'h00, 8'h00, 8'h00, 8'h00);
        check_all("partial1", 8'h00, 8'h01, 0, 0, 0, 16'd1);
        send(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check_all("partial2", 8'h80, 8'h81, 0, 0, 0, 16'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all("rst_mid", 8'h00, 8'h00, 0, 0, 0, 16'd0);

        // Back-to-back words, one per cycle.
        drive(8'h00, 8'h00, 8'h00, 8'h00);
        drive(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check_val("b2b_first.mask", 32'(known_mask), 32'h01);
        tick();
        check_all("b2b_second", 8'h80, 8'h81, 0, 0, 0, 16'd2);
        // Completes the mask but minterm 0 contradicts the stored 0.
        send(8'hF0, 8'hCC, 8'hAA, 8'hCD);
        check_all("lock_and_conflict", 8'h80, 8'h81, 0, 0, 1, 16'd3);
        do_clear();

        send(8'h00, 8'h00, 8'h00, 8'h01);
        check_all("intra_conflict", 8'h00, 8'h00, 0, 0, 1, 16'd1);
        send(8'hF0, 8'hCC, 8'hAA, 8'hCC);
        check_all("error_absorb", 8'h00, 8'h00, 0, 0, 1, 16'd2);
        do_clear();
        check_all("clear2", 8'h00, 8'h00, 0, 0, 0, 16'd0);

        send(8'hF0, 8'hCC, 8'hAA, 8'hCC);
        send(8'h00, 8'h00, 8'h00, 8'hFF);
        check_all("post_lock_mismatch", 8'hCC, 8'hFF, 0, 0, 1, 16'd2);
        do_clear();

        // Clear and a locking word in the same cycle: the word is discarded.
        clear = 1'b1;
        drive(8'hF0, 8'hCC, 8'hAA, 8'hCC);
        clear = 1'b0;
        tick();
        check_all("clear_collide", 8'h00, 8'h00, 0, 0, 0, 16'd0);
        // Clear one cycle later drops the word already staged.
        drive(8'hF0, 8'hCC, 8'hAA, 8'hCC);
        do_clear();
        tick();
        check_all("clear_staged", 8'h00, 8'h00, 0, 0, 0, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rop3_mode_recover.md
# rop3_mode_recover

Observer that recovers the 8-bit ROP3 mode code from a stream of operand/result words. It is the decoding end of the `rop3_lut256` / `rop3_smart` datapath: those blocks map (Mode, P, S, D) to Result, and this block maps observed (P, S, D, Result) back to Mode. It sits beside a ROP3 engine in self-check and bring-up builds. It accumulates truth-table evidence across cycles, reports lock once all 8 minterms are known, and flags any inconsistent observation.

## Interface
Parameters:
- N, 8, operand/result width in bits (N ≥ 1)
- CNT_W, 16, width of the saturating observation-word counter

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous soft clear; same effect as rst
- in_valid  in  1  the P/S/D/Result words on this cycle are an observation
- P  in  N  pattern operand
- S  in  N  source operand
- D  in  N  destination operand
- Result  in  N  ROP3 output for these operands
- Mode_out  out  8  recovered mode bits (unknown bits read 0)
- known_mask  out  8  bit i set means Mode bit i has been observed
- out_valid  out  1  one-cycle pulse on the IDLE/COLLECT→LOCKED transition
- locked  out  1  high in LOCKED
- conflict  out  1  sticky; high in ERROR
- obs_cnt  out  CNT_W  count of accepted observation words, saturating at all-ones

## Operation
- Minterm index per bit position j: idx = {P[j], S[j], D[j]}, so idx = 4·P + 2·S + D. Observation: Mode[idx] == Result[j].
- Stage 1 registers in_valid, P, S, D and Result. Stage 2 merges all N observations of the staged word into the accumulator.
- Merge per idx: `hit` if any j maps to idx. `val1` if any such j has Result 1. `val0` if any such j has Result 0.
- Merge conflict: the word is inconsistent if, for any idx, val1 and val0 are both set, or known_mask[idx] is set and the stored bit differs from the observed value.
- Consistent word: known_mask |= hit. Mode_out[idx] = val1 for every hit idx.
- Inconsistent word: go to ERROR and leave known_mask and Mode_out unchanged.
- Every staged valid word increments obs_cnt, with saturation.
- FSM states: IDLE, COLLECT, LOCKED, ERROR.
  - IDLE: first valid staged word → COLLECT, or → LOCKED if it completes the mask, or → ERROR if inconsistent.
  - COLLECT: mask becomes 8'hFF → LOCKED and pulse out_valid. Inconsistent word → ERROR.
  - LOCKED: valid words are still checked. A mismatch → ERROR and clears locked. Mode_out stays frozen.
  - ERROR: absorbing until rst or clear. Words are counted but not merged.
- rst or clear: state IDLE, stage-1 valid cleared, all outputs 0. If clear and in_valid are both high, clear wins and the word is discarded. Clear also drops any word already in stage 1.
- in_valid low: the cycle has no effect; the pipeline bubble propagates.

## Timing
- Reset values: Mode_out=0, known_mask=0, out_valid=0, locked=0, conflict=0, obs_cnt=0, state IDLE.
- Latency: a word with in_valid high at edge k updates the outputs at edge k+1.
- Throughput: one word per cycle, no backpressure.
- out_valid is high for exactly one cycle, during the cycle after the locking edge. It never reasserts without a clear.
- Conflict and lock in the same word resolve to ERROR; out_valid is not pulsed.
- obs_cnt holds at 2^CNT_W−1.

## Structure
- Package `rop3_pkg`: state enum (IDLE, COLLECT, LOCKED, ERROR), the minterm-index function, and the MODE_W=8 constant. This package is shared with the ROP3 engines.
- Sub-module `rop3_minterm_merge`: purely combinational. It takes P, S, D, Result, known_mask and Mode_out, and produces hit[7:0], val[7:0] and bad. The top level holds the stage registers, FSM and counter.

## Test plan
- Mode 8'hCC (Result=S): P=F0, S=CC, D=AA, Result=CC, single word → Mode_out=CC, known_mask=FF, out_valid pulse 2 cycles after drive, locked=1, obs_cnt=1.
- Mode 8'h5A (P^D): same operands, Result=5A → Mode_out=5A, locked. A follow-up word P=FF, S=00, D=0F, Result=F0 keeps the lock with no conflict.
- Partial coverage:
  - word 1: P=S=D=00, Result=00 → known_mask=01
  - word 2: P=S=D=FF, Result=FF → known_mask=81, Mode_out=80, state COLLECT, no out_valid
- Intra-word conflict: P=S=D=00, Result=01 → conflict=1, known_mask=00. A later clear → all outputs 0.
- Post-lock mismatch: lock on CC, then P=S=D=00, Result=FF → conflict=1, locked=0, Mode_out stays CC.
- Clear collision: clear and in_valid high together with a locking word → outputs stay 0 next cycle. rst asserted mid-COLLECT → IDLE on the next edge.
